// File: rtl/dvsd_cmp_pkg.sv
// Shared types for the comparator result monitor: FSM states,
// result codes and the flag classifier.
package dvsd_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mon_state_t;

    typedef logic [1:0] res_t;

    localparam res_t RES_LT  = 2'd0;
    localparam res_t RES_EQ  = 2'd1;
    localparam res_t RES_GT  = 2'd2;
    localparam res_t RES_ERR = 2'd3;

    // Anything other than exactly one flag high is malformed.
    function automatic res_t classify(
        input logic lt,
        input logic eq,
        input logic gt
    );
        res_t r;
        unique case ({lt, eq, gt})
            3'b100:  r = RES_LT;
            3'b010:  r = RES_EQ;
            3'b001:  r = RES_GT;
            default: r = RES_ERR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dvsd_cmp_monitor_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module dvsd_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && count != MAX) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dvsd_cmp_monitor.sv
// Windowed tally of comparator flag results with one-cycle done pulse.
// Optional longest-run tracking via DVSD_CMP_MON_STREAK_EN.
module dvsd_cmp_monitor
    import dvsd_cmp_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             less_than,
    input  logic             equal_to,
    input  logic             greater_than,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             onehot_err
`ifdef DVSD_CMP_MON_STREAK_EN
    ,
    output logic [CNT_W-1:0] max_streak
`endif
);

    localparam int WIN_W = $clog2(WIN_LEN + 1);
    localparam logic [WIN_W-1:0] WIN_END = WIN_W'(WIN_LEN);

    mon_state_t       state;
    mon_state_t       state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic             go;
    logic             take;
    logic             win_last;
    res_t             res;

    assign go       = (state == IDLE) && start;
    assign take     = (state == RUN) && sample_valid;
    assign res      = classify(less_than, equal_to, greater_than);
    assign win_last = take && (win_cnt + WIN_W'(1) == WIN_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (win_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            onehot_err <= 1'b0;
        end else if (go) begin
            win_cnt    <= '0;
            onehot_err <= 1'b0;
        end else if (take) begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (res == RES_ERR) onehot_err <= 1'b1;
        end
    end

    dvsd_sat_counter #(.CNT_W(CNT_W)) u_lt (
        .clk(clk), .rst_n(rst_n), .clear(go),
        .en(take && res == RES_LT), .count(lt_count)
    );

    dvsd_sat_counter #(.CNT_W(CNT_W)) u_eq (
        .clk(clk), .rst_n(rst_n), .clear(go),
        .en(take && res == RES_EQ), .count(eq_count)
    );

    dvsd_sat_counter #(.CNT_W(CNT_W)) u_gt (
        .clk(clk), .rst_n(rst_n), .clear(go),
        .en(take && res == RES_GT), .count(gt_count)
    );

    dvsd_sat_counter #(.CNT_W(CNT_W)) u_err (
        .clk(clk), .rst_n(rst_n), .clear(go),
        .en(take && res == RES_ERR), .count(err_count)
    );

`ifdef DVSD_CMP_MON_STREAK_EN
    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] cur_nxt;
    res_t             prev_res;

    always_comb begin
        cur_nxt = CNT_W'(1);
        if (res == RES_ERR) begin
            cur_nxt = '0;
        end else if (res == prev_res && cur != '0) begin
            cur_nxt = (cur == '1) ? cur : cur + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            prev_res <= RES_ERR;
        end else if (go) begin
            cur      <= '0;
            prev_res <= RES_ERR;
        end else if (take) begin
            cur      <= cur_nxt;
            prev_res <= res;
        end
    end

    // The running streak never exceeds the max by more than one,
    // so the max only ever needs to step up by one.
    dvsd_sat_counter #(.CNT_W(CNT_W)) u_streak (
        .clk(clk), .rst_n(rst_n), .clear(go),
        .en(take && cur_nxt > max_streak), .count(max_streak)
    );
`endif

endmodule

// File: tb/tb_dvsd_cmp_monitor.sv
// Directed self-checking bench for dvsd_cmp_monitor; several instances
// with different parameters share the sample inputs, each with its own start.
module tb_dvsd_cmp_monitor;

    logic       clk;
    logic       rst_n;
    logic [3:0] start;
    logic       valid;
    logic       lt;
    logic       eq;
    logic       gt;

    logic       a_busy, a_done, a_oh;
    logic [7:0] a_lt, a_eq, a_gt, a_err;
    logic       b_busy, b_done, b_oh;
    logic [7:0] b_lt, b_eq, b_gt, b_err;
    logic       c_busy, c_done, c_oh;
    logic [3:0] c_lt, c_eq, c_gt, c_err;

    int errors = 0;
    int checks = 0;
    int a_pulses = 0;

    int pa[16] = '{8, 2, 10, 7, 11, 3, 15, 1, 5, 6, 0, 12, 8, 2, 10, 7};
    int pb[16] = '{9, 14, 10, 6, 15, 13, 15, 12, 4, 9, 0, 3, 9, 14, 10, 6};

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DVSD_CMP_MON_STREAK_EN
    logic [7:0] a_ms, b_ms, d_ms;
    logic [3:0] c_ms;
    logic       d_busy, d_done, d_oh;
    logic [7:0] d_lt, d_eq, d_gt, d_err;

    dvsd_cmp_monitor #(.CNT_W(8), .WIN_LEN(8)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start[3]),
        .sample_valid(valid), .less_than(lt), .equal_to(eq),
        .greater_than(gt), .busy(d_busy), .done(d_done),
        .lt_count(d_lt), .eq_count(d_eq), .gt_count(d_gt),
        .err_count(d_err), .onehot_err(d_oh), .max_streak(d_ms)
    );
`endif

    dvsd_cmp_monitor #(.CNT_W(8), .WIN_LEN(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .sample_valid(valid), .less_than(lt), .equal_to(eq),
        .greater_than(gt), .busy(a_busy), .done(a_done),
        .lt_count(a_lt), .eq_count(a_eq), .gt_count(a_gt),
        .err_count(a_err), .onehot_err(a_oh)
`ifdef DVSD_CMP_MON_STREAK_EN
        , .max_streak(a_ms)
`endif
    );

    dvsd_cmp_monitor #(.CNT_W(8), .WIN_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .sample_valid(valid), .less_than(lt), .equal_to(eq),
        .greater_than(gt), .busy(b_busy), .done(b_done),
        .lt_count(b_lt), .eq_count(b_eq), .gt_count(b_gt),
        .err_count(b_err), .onehot_err(b_oh)
`ifdef DVSD_CMP_MON_STREAK_EN
        , .max_streak(b_ms)
`endif
    );

    dvsd_cmp_monitor #(.CNT_W(4), .WIN_LEN(20)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]),
        .sample_valid(valid), .less_than(lt), .equal_to(eq),
        .greater_than(gt), .busy(c_busy), .done(c_done),
        .lt_count(c_lt), .eq_count(c_eq), .gt_count(c_gt),
        .err_count(c_err), .onehot_err(c_oh)
`ifdef DVSD_CMP_MON_STREAK_EN
        , .max_streak(c_ms)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (a_done) a_pulses++;
    endtask

    task automatic drive(input logic v, input logic l, input logic e,
                         input logic g, input logic st);
        tick();
        start = {3'b000, st};
        valid = v;
        lt    = l;
        eq    = e;
        gt    = g;
    endtask

    // Start cycle carries a valid sample that must be ignored.
    task automatic kick(input logic [3:0] m);
        tick();
        start = m;
        valid = 1'b1;
        lt    = 1'b0;
        eq    = 1'b1;
        gt    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        valid = 1'b0;
        lt    = 1'b0;
        eq    = 1'b0;
        gt    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_counts", {a_lt, a_eq, a_gt, a_err}, 0);
        chk("rst_onehot", a_oh, 0);

        // Reset in the middle of a window.
        kick(4'b0001);
        repeat (5) drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("mid_busy", a_busy, 1);
        chk("mid_eq", a_eq, 5);
        rst_n = 1'b0;
        #1;
        chk("async_busy", a_busy, 0);
        chk("async_counts", {a_lt, a_eq, a_gt, a_err}, 0);
        chk("async_done", a_done, 0);
        tick();
        rst_n = 1'b1;

        // Standard 16-sample window.
        a_pulses = 0;
        kick(4'b0001);
        for (int i = 0; i < 16; i++) begin
            drive(1, pa[i] < pb[i], pa[i] == pb[i], pa[i] > pb[i], 0);
            if (i == 1) chk("std_busy_run", a_busy, 1);
        end
        drive(0, 0, 0, 0, 0);
        chk("std_done", a_done, 1);
        chk("std_busy_done", a_busy, 0);
        chk("std_lt", a_lt, 8);
        chk("std_eq", a_eq, 4);
        chk("std_gt", a_gt, 4);
        chk("std_err", a_err, 0);
`ifdef DVSD_CMP_MON_STREAK_EN
        chk("std_streak", a_ms, 2);
`endif
        drive(0, 0, 0, 0, 0);
        chk("std_done_off", a_done, 0);
        chk("std_pulses", a_pulses, 1);
        chk("std_hold_lt", a_lt, 8);

        // Gaps with junk flags, plus start pulses mid-RUN.
        a_pulses = 0;
        kick(4'b0001);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) drive(0, 1, 1, 1, i == 3 || i == 9);
            drive(1, pa[i] < pb[i], pa[i] == pb[i], pa[i] > pb[i], 0);
        end
        chk("gap_pulses_before", a_pulses, 0);
        drive(0, 0, 0, 0, 0);
        chk("gap_done", a_done, 1);
        chk("gap_counts", {a_lt, a_eq, a_gt, a_err}, {8'd8, 8'd4, 8'd4, 8'd0});
        chk("gap_onehot", a_oh, 0);
        drive(0, 0, 0, 0, 0);
        chk("gap_pulses", a_pulses, 1);

        // Malformed flags on the 4-sample instance.
        kick(4'b0010);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        chk("bad_no_done", b_done, 0);
        drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("bad_done", b_done, 1);
        chk("bad_lt", b_lt, 1);
        chk("bad_eq", b_eq, 1);
        chk("bad_gt", b_gt, 0);
        chk("bad_err", b_err, 2);
        chk("bad_onehot", b_oh, 1);
        drive(0, 0, 0, 0, 0);
        chk("bad_sticky", b_oh, 1);
        chk("idle_hold_a", {a_lt, a_eq, a_gt}, {8'd8, 8'd4, 8'd4});
        kick(4'b0010);
        drive(0, 0, 0, 0, 0);
        chk("bad_restart_oh", b_oh, 0);
        chk("bad_restart_err", b_err, 0);
        chk("bad_restart_busy", b_busy, 1);

        // Saturation with 4-bit counters over 20 samples.
        kick(4'b0100);
        repeat (20) drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("sat_done", c_done, 1);
        chk("sat_eq", c_eq, 15);
        chk("sat_other", {c_lt, c_gt, c_err}, 0);
        drive(0, 0, 0, 0, 0);
        chk("sat_idle", {c_busy, c_done}, 0);

`ifdef DVSD_CMP_MON_STREAK_EN
        kick(4'b1000);
        repeat (3) drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        repeat (4) drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("streak_done", d_done, 1);
        chk("streak_max", d_ms, 4);
        chk("streak_err", d_err, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dvsd_cmp_monitor.md
Name: dvsd_cmp_monitor

Overview:
- Downstream consumer of the 4-bit magnitude comparator's three flag outputs (less_than, equal_to, greater_than).
- Over a programmable window of valid samples, counts how many results were less-than, equal and greater-than, and counts malformed (non-one-hot) flag sets.
- Presents the results to the status/readout logic with a one-cycle done pulse.

Parameters:
- CNT_W, 8: width of each result counter; counters saturate at 2^CNT_W-1.
- WIN_LEN, 16: number of valid samples per measurement window; legal range 1..2^16-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new window; sampled only in IDLE.
- sample_valid  in  1  comparator flags on this cycle are a sample.
- less_than  in  1  comparator flag, A_in < B_in.
- equal_to  in  1  comparator flag, A_in == B_in.
- greater_than  in  1  comparator flag, A_in > B_in.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse when a window completes.
- lt_count  out  CNT_W  less-than sample count.
- eq_count  out  CNT_W  equal sample count.
- gt_count  out  CNT_W  greater-than sample count.
- err_count  out  CNT_W  count of non-one-hot samples.
- onehot_err  out  1  sticky; set on any malformed sample, cleared by start.

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE, busy=0, done=0, all counts=0, onehot_err=0, window counter=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 -> RUN next cycle; clears all counts, onehot_err and the window counter on that edge.
  - sample_valid is ignored in IDLE, including on the start cycle.
- RUN:
  - Each cycle with sample_valid=1 increments the window counter (width $clog2(WIN_LEN+1)).
  - Exactly one flag high: increment the matching count.
  - Zero flags or more than one flag high: increment err_count, set onehot_err; no category count changes.
  - Malformed samples still consume a window slot.
  - When the sample making the window counter equal WIN_LEN is accepted -> DONE next cycle.
  - start is ignored in RUN.
  - Cycles with sample_valid=0 have no effect.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - Returns unconditionally to IDLE; start in DONE is ignored.
- Counts are registered and update the cycle after the accepted sample.
- Counts hold their values in IDLE until the next start.
- Saturation: any counter at 2^CNT_W-1 stays there; the window counter does not saturate.
- Latency: done asserts one cycle after the final sample edge.
- busy is 1 exactly while in RUN.
- WIN_LEN=1: a single sample goes RUN -> DONE.

Optional Feature:
- Macro: DVSD_CMP_MON_STREAK_EN.
- When defined:
  - Adds output max_streak (CNT_W).
  - max_streak is the longest run of consecutive valid samples with the same well-formed result within the window.
  - A malformed sample breaks the run.
  - Cleared by start and reset; saturates at 2^CNT_W-1.
  - Updates with the same one-cycle latency as the counts.
- When undefined: no port, no streak logic.

Decomposition:
- Shared package dvsd_cmp_pkg holds:
  - state enum mon_state_t (IDLE, RUN, DONE);
  - result encoding constants RES_LT, RES_EQ, RES_GT, RES_ERR;
  - a function classifying the three flags into a result code.
- One sub-module, dvsd_sat_counter: parameterised CNT_W, with clear, enable and saturating increment; instantiated four times (five with streak).

Test Plan:
- Reset in mid-window: start, 5 samples accepted, rst_n low for 1 cycle -> all outputs 0, busy=0, next start behaves normally.
- Standard window: WIN_LEN=16, feed the comparator over pairs (8,9),(2,14),(10,10),(7,6),(11,15),(3,13),(15,15),(1,12),(5,4),(6,9),(0,0),(12,3),(8,9),(2,14),(10,10),(7,6) -> lt=8, eq=4, gt=4, err=0; done pulses once, one cycle after the 16th sample.
- Gaps and ignored start: same stimulus with sample_valid low on alternating cycles and start pulsed twice mid-RUN -> identical counts; done pulses only after the 16th valid sample.
- Malformed flags: WIN_LEN=4, samples {lt}, {lt+gt}, {none}, {eq} -> lt=1, eq=1, gt=0, err=2, onehot_err=1, done after 4th sample.
- Saturation: CNT_W=4, WIN_LEN=20, all samples equal_to -> eq_count=15, other counts 0.
- Streak (macro defined): WIN_LEN=8, results gt,gt,gt,err,lt,lt,lt,lt -> max_streak=4; without macro the build elaborates with no max_streak port.
